// File: rtl/key_speed_ctrl_if.sv
// KEY/speed bundle between the board buttons and the scrolling display.
// The board side drives KEY; key_speed_ctrl drives everything else.
interface key_speed_if;
    logic [3:0] KEY;
    logic [5:0] speed;
    logic [3:0] key_down;
    logic       inc_pulse;
    logic       dec_pulse;
    logic       at_min;
    logic       at_max;

    modport master (
        output KEY,
        input  speed, key_down, inc_pulse, dec_pulse, at_min, at_max
    );

    modport slave (
        input  KEY,
        output speed, key_down, inc_pulse, dec_pulse, at_min, at_max
    );
endinterface

// File: rtl/key_speed_ctrl.sv
// Debounced KEY front end producing press steps and a saturating scroll speed.
// Define KEY_SPEED_AUTOREPEAT_EN to add hold-to-repeat on KEY[1]/KEY[2].
//   state  | meaning
//   IDLE   | no inc/dec key owns the repeat timer
//   HOLD   | owner held, waiting REPEAT_DELAY before the first repeat
//   REPEAT | owner still held, stepping every REPEAT_RATE cycles
module key_speed_ctrl #(
    parameter int unsigned DEBOUNCE_CYC = 1000000,
    parameter int unsigned SPEED_INIT   = 3,
    parameter int unsigned SPEED_MIN    = 1,
    parameter int unsigned SPEED_MAX    = 51,
    parameter int unsigned REPEAT_DELAY = 25000000,
    parameter int unsigned REPEAT_RATE  = 5000000
) (
    input logic        CLOCK_50,
    input logic        RST_N,
    key_speed_if.slave bus
);
    localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);

    if (SPEED_MAX > 63 || SPEED_MIN > SPEED_INIT || SPEED_INIT > SPEED_MAX ||
        DEBOUNCE_CYC == 0 || REPEAT_DELAY == 0 || REPEAT_RATE == 0) begin : g_bad_cfg
        $error("key_speed_ctrl: inconsistent parameter set");
    end

    logic            rst_meta, rst_int;
    logic [3:0]      sync_a, sync_b, lvl, key_down_r;
    logic [DB_W-1:0] db_cnt [4];
    logic [2:0]      key_down_q, press, blocked;
    logic [1:0]      settle_cnt;
    logic            settled;
    logic [5:0]      speed_r;
    logic            inc_r, dec_r, step_inc, step_dec;

    // Assert asynchronously, release synchronously.
    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            rst_meta <= 1'b0;
            rst_int  <= 1'b0;
        end else begin
            rst_meta <= 1'b1;
            rst_int  <= rst_meta;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst_int) begin
        if (!rst_int) begin
            sync_a <= 4'hF;
            sync_b <= 4'hF;
        end else begin
            sync_a <= bus.KEY;
            sync_b <= sync_a;
        end
    end

    assign lvl = ~sync_b;

    always_ff @(posedge CLOCK_50 or negedge rst_int) begin
        if (!rst_int) begin
            key_down_r <= '0;
            for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (lvl[i] == key_down_r[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYC - 1)) begin
                    key_down_r[i] <= ~key_down_r[i];
                    db_cnt[i]     <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // A key already held when reset releases must be let go before it can press.
    assign settled = (settle_cnt == 2'd2);

    always_ff @(posedge CLOCK_50 or negedge rst_int) begin
        if (!rst_int) begin
            settle_cnt <= '0;
            blocked    <= '1;
            key_down_q <= '0;
        end else begin
            if (!settled) settle_cnt <= settle_cnt + 2'd1;
            for (int i = 0; i < 3; i++) begin
                if (settled && !lvl[i] && !key_down_r[i]) blocked[i] <= 1'b0;
            end
            key_down_q <= key_down_r[2:0];
        end
    end

    assign press = key_down_r[2:0] & ~key_down_q & ~blocked;

`ifdef KEY_SPEED_AUTOREPEAT_EN
    localparam int unsigned TM_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int          TM_W   = $clog2(TM_MAX + 1);

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

    state_t          state, state_nxt;
    logic            owner, owner_nxt;
    logic            owner_down, tc;
    logic [TM_W-1:0] timer, timer_nxt;

    always_ff @(posedge CLOCK_50 or negedge rst_int) begin
        if (!rst_int) begin
            state <= IDLE;
            owner <= 1'b0;
            timer <= '0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            timer <= timer_nxt;
        end
    end

    assign owner_down = owner ? key_down_r[2] : key_down_r[1];
    assign tc = (state == HOLD) ? (timer == TM_W'(REPEAT_DELAY - 1))
                                : (timer == TM_W'(REPEAT_RATE - 1));

    // owner 0 = KEY[1] increments, owner 1 = KEY[2] decrements.
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        timer_nxt = timer;
        step_inc  = 1'b0;
        step_dec  = 1'b0;
        case (state)
            IDLE: begin
                step_inc = press[1];
                step_dec = press[2];
                if (!press[0] && (press[1] || press[2])) begin
                    owner_nxt = ~press[1];
                    timer_nxt = '0;
                    state_nxt = HOLD;
                end
            end
            HOLD, REPEAT: begin
                if (press[0] || !owner_down) begin
                    timer_nxt = '0;
                    state_nxt = IDLE;
                end else if (tc) begin
                    step_inc  = ~owner;
                    step_dec  = owner;
                    timer_nxt = '0;
                    state_nxt = REPEAT;
                end else begin
                    timer_nxt = timer + TM_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
`else
    assign step_inc = press[1];
    assign step_dec = press[2];
`endif

    // Increment beats decrement when both step in the same cycle.
    always_ff @(posedge CLOCK_50 or negedge rst_int) begin
        if (!rst_int) begin
            speed_r <= 6'(SPEED_INIT);
            inc_r   <= 1'b0;
            dec_r   <= 1'b0;
        end else begin
            inc_r <= 1'b0;
            dec_r <= 1'b0;
            if (press[0]) begin
                speed_r <= 6'(SPEED_INIT);
            end else if (step_inc) begin
                if (speed_r < 6'(SPEED_MAX)) begin
                    speed_r <= speed_r + 6'd1;
                    inc_r   <= 1'b1;
                end
            end else if (step_dec) begin
                if (speed_r > 6'(SPEED_MIN)) begin
                    speed_r <= speed_r - 6'd1;
                    dec_r   <= 1'b1;
                end
            end
        end
    end

    assign bus.speed     = speed_r;
    assign bus.key_down  = key_down_r;
    assign bus.inc_pulse = inc_r;
    assign bus.dec_pulse = dec_r;
    assign bus.at_min    = (speed_r == 6'(SPEED_MIN));
    assign bus.at_max    = (speed_r == 6'(SPEED_MAX));
endmodule
